// File: rtl/fifo_packetizer.sv
// Framing stage behind a FIFO read port: drains 32-bit words and emits
// header + PKT_WORDS payload words + checksum trailer on a valid/ready stream.
module fifo_packetizer #(
    parameter int unsigned PKT_WORDS = 16,
    parameter logic [7:0]  MAGIC     = 8'hA5
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ack,
    output logic [31:0] pkt_data,
    output logic        pkt_valid,
    output logic        pkt_last,
    input  logic        pkt_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, PAYLOAD, TRAILER} state_t;

    localparam logic [15:0] LEN      = 16'(PKT_WORDS);
    localparam logic [15:0] LAST_CNT = 16'(PKT_WORDS - 1);

    state_t      state;
    logic [7:0]  seq;
    logic [31:0] sum;
    logic [15:0] cnt;
    logic        slot_free;
    logic        in_xfer;

    function automatic logic [31:0] header_word(input logic [7:0] s);
        return {MAGIC, s, LEN};
    endfunction

    function automatic logic [31:0] sum_add(input logic [31:0] a, input logic [31:0] b);
        return a + b;
    endfunction

    // The output slot can take a new word when empty or draining this edge.
    always_comb begin
        slot_free = !pkt_valid || pkt_ready;
        in_ack    = (state == PAYLOAD) && slot_free && !rst;
        in_xfer   = in_valid && in_ack;
        busy      = (state != IDLE) || pkt_valid;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            seq       <= 8'd0;
            sum       <= 32'd0;
            cnt       <= 16'd0;
            pkt_data  <= 32'd0;
            pkt_valid <= 1'b0;
            pkt_last  <= 1'b0;
        end else begin
            if (slot_free) begin
                pkt_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    // Header waits for the first payload word to be present.
                    if (in_valid && slot_free) begin
                        pkt_data  <= header_word(seq);
                        pkt_valid <= 1'b1;
                        pkt_last  <= 1'b0;
                        sum       <= 32'd0;
                        cnt       <= 16'd0;
                        state     <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (in_xfer) begin
                        pkt_data  <= in_data;
                        pkt_valid <= 1'b1;
                        pkt_last  <= 1'b0;
                        sum       <= sum_add(sum, in_data);
                        cnt       <= cnt + 16'd1;
                        if (cnt == LAST_CNT) begin
                            state <= TRAILER;
                        end
                    end
                end
                TRAILER: begin
                    if (slot_free) begin
                        pkt_data  <= sum;
                        pkt_valid <= 1'b1;
                        pkt_last  <= 1'b1;
                        seq       <= seq + 8'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_packetizer.sv
// Randomized bench for fifo_packetizer against a queue-based packet model.
module tb_fifo_packetizer;

    localparam int PKT = 4;

    logic        clock;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ack;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_last;
    logic        pkt_ready;
    logic        busy;

    int          checks;
    int          errors;
    logic [7:0]  mseq;
    logic [31:0] obs_hdr [0:299];
    logic [31:0] last_trailer;

    fifo_packetizer #(.PKT_WORDS(PKT), .MAGIC(8'hA5)) dut (
        .clock    (clock),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ack   (in_ack),
        .pkt_data (pkt_data),
        .pkt_valid(pkt_valid),
        .pkt_last (pkt_last),
        .pkt_ready(pkt_ready),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    // mode: 0 = words 1..PKT, 1 = random, 2 = checksum-wrap pattern
    // ready_pct < 0 selects the 1,0,0 ready pattern; gap starves input after word 2
    task automatic run_stream(input int npkts, input int mode, input int ready_pct,
                              input int valid_pct, input bit gap);
        logic [31:0] src[$];
        logic [31:0] exp_q[$];
        logic        exp_l[$];
        logic [31:0] wrap_pat[4];
        logic [31:0] s;
        logic [31:0] w;
        logic [31:0] prev_data;
        logic        prev_hold;
        int cyc, first_in, first_out, last_out, nout, consumed, g, budget;
        wrap_pat[0] = 32'hFFFF_FFFF;
        wrap_pat[1] = 32'hFFFF_FFFF;
        wrap_pat[2] = 32'h0000_0002;
        wrap_pat[3] = 32'h0000_0000;
        for (int p = 0; p < npkts; p++) begin
            s = 32'd0;
            exp_q.push_back({8'hA5, mseq, 16'(PKT)});
            exp_l.push_back(1'b0);
            for (int i = 0; i < PKT; i++) begin
                if (mode == 0)      w = 32'(i + 1);
                else if (mode == 2) w = wrap_pat[i % 4];
                else                w = $urandom;
                src.push_back(w);
                exp_q.push_back(w);
                exp_l.push_back(1'b0);
                s += w;
            end
            exp_q.push_back(s);
            exp_l.push_back(1'b1);
            mseq++;
        end
        cyc = 0; first_in = -1; first_out = -1; last_out = -1; nout = 0;
        consumed = 0; g = 0; prev_hold = 1'b0; prev_data = 32'd0;
        budget = npkts * (PKT + 2) * 20 + 100;
        while (exp_q.size() > 0 && cyc < budget) begin
            @(negedge clock);
            in_valid  = (src.size() > 0) && ($urandom_range(99) < valid_pct);
            in_data   = (src.size() > 0) ? src[0] : $urandom;
            pkt_ready = (ready_pct < 0) ? (cyc % 3 == 0) : ($urandom_range(99) < ready_pct);
            if (gap && consumed == 2 && g < 5) in_valid = 1'b0;
            #1;
            if (gap && consumed == 2 && g < 5) begin
                if (g >= 1) check("gap_valid", pkt_valid, 1'b0);
                g++;
            end
            if (prev_hold) begin
                check("hold_data", pkt_data, prev_data);
                check("hold_valid", pkt_valid, 1'b1);
            end
            if (pkt_valid && !pkt_ready) check("bp_ack", in_ack, 1'b0);
            prev_hold = pkt_valid && !pkt_ready;
            prev_data = pkt_data;
            if (in_valid && first_in < 0) first_in = cyc;
            if (pkt_valid && pkt_ready) begin
                check("data", pkt_data, exp_q.pop_front());
                check("last", pkt_last, exp_l.pop_front());
                check("busy", busy, 1'b1);
                if (nout % (PKT + 2) == 0 && nout / (PKT + 2) < 300)
                    obs_hdr[nout / (PKT + 2)] = pkt_data;
                if (pkt_last) last_trailer = pkt_data;
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                nout++;
            end
            if (in_valid && in_ack) begin
                void'(src.pop_front());
                consumed++;
            end
            cyc++;
        end
        check("timeout_left", exp_q.size(), 0);
        if (ready_pct == 100 && valid_pct == 100 && !gap) begin
            check("hdr_latency", first_out - first_in, 1);
            check("contiguous", last_out - first_out, npkts * (PKT + 2) - 1);
        end
        @(negedge clock);
        in_valid  = 1'b0;
        pkt_ready = 1'b1;
        #1;
        check("idle_valid", pkt_valid, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mseq = 8'd0;
        last_trailer = 32'd0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 32'd0;
        pkt_ready = 1'b0;
        #3;
        check("rst_valid", pkt_valid, 1'b0);
        check("rst_last", pkt_last, 1'b0);
        check("rst_data", pkt_data, 32'd0);
        check("rst_ack", in_ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;

        run_stream(1, 0, 100, 100, 1'b0);
        check("basic_hdr", obs_hdr[0], 32'hA500_0004);
        check("basic_trl", last_trailer, 32'h0000_000A);

        run_stream(2, 0, -1, 100, 1'b0);
        check("bp_trl", last_trailer, 32'h0000_000A);

        run_stream(1, 0, 100, 100, 1'b1);
        check("gap_trl", last_trailer, 32'h0000_000A);

        run_stream(1, 2, 100, 100, 1'b0);
        check("wrap_trl", last_trailer, 32'h0000_0000);

        run_stream(20, 1, 60, 70, 1'b0);

        // Asynchronous reset with a packet in flight.
        @(negedge clock);
        in_valid = 1'b1; in_data = 32'h11; pkt_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        in_data = 32'h22;
        @(negedge clock);
        #1;
        check("pre_rst_data", pkt_data, 32'h22);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", pkt_valid, 1'b0);
        check("mid_rst_last", pkt_last, 1'b0);
        check("mid_rst_ack", in_ack, 1'b0);
        check("mid_rst_data", pkt_data, 32'd0);
        check("mid_rst_busy", busy, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        rst = 1'b0;
        mseq = 8'd0;

        run_stream(257, 1, 100, 100, 1'b0);
        check("post_rst_hdr", obs_hdr[0], 32'hA500_0004);
        check("seq_hdr_256", obs_hdr[255], 32'hA5FF_0004);
        check("seq_hdr_257", obs_hdr[256], 32'hA500_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_packetizer.md
# fifo_packetizer

Single-clock framing stage that sits directly downstream of the `fifo` read port. It drains 32-bit words from the FIFO's valid/ack interface and emits fixed-length packets on a valid/ready stream: one header word, `PKT_WORDS` payload words, then one checksum trailer word. Payload words are passed through unmodified and in order.

## Interface
- `PKT_WORDS`, default 16: payload words per packet, legal range 1..65535.
- `MAGIC`, default 8'hA5: constant placed in header bits [31:24].
- `clock` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input 32: FIFO `data_out`.
- `in_valid` input 1: FIFO `data_out_valid`.
- `in_ack` output 1: to FIFO `data_out_ack`. A word transfers on an edge where `in_valid && in_ack`.
- `pkt_data` output 32: packet word.
- `pkt_valid` output 1: `pkt_data` is valid.
- `pkt_last` output 1: marks the trailer word.
- `pkt_ready` input 1: downstream accepts. A word transfers on an edge where `pkt_valid && pkt_ready`.
- `busy` output 1: high when the state is not IDLE or `pkt_valid` is high.

## Operation
- **Output register.** `pkt_data`, `pkt_valid` and `pkt_last` are registered. `slot_free = !pkt_valid || pkt_ready`. The register loads only when `slot_free`. When `slot_free` is high and nothing is loaded, `pkt_valid` goes low on the next edge.
- **FSM states:** IDLE, PAYLOAD, TRAILER.
- **IDLE:**
  - `in_ack`=0.
  - If `in_valid && slot_free`: load header `{MAGIC, seq[7:0], PKT_WORDS[15:0]}` with `pkt_last`=0, clear `sum` and `cnt`, go to PAYLOAD.
  - No header is emitted until the first payload word is present.
- **PAYLOAD:**
  - `in_ack = slot_free` (combinational, and 0 while `rst` is high).
  - On a transfer: load `in_data` into the output register, `sum <= sum + in_data` (mod 2^32), `cnt <= cnt + 1`.
  - When the accepted word is the `PKT_WORDS`-th, go to TRAILER.
  - While `in_valid`=0 the state is held and `pkt_valid` drops after the pending word drains. There is no timeout and no partial packet.
- **TRAILER:**
  - `in_ack`=0.
  - When `slot_free`: load the final `sum` (including the last payload word) with `pkt_last`=1, `seq <= seq + 1` (8-bit, 0xFF wraps to 0x00), go to IDLE.
- **Counter widths:** `cnt` is 16 bits and `sum` is 32 bits. Overflow of `sum` is silently discarded.
- **Reset (asynchronous, any time, including mid-packet):**
  - Outputs: `pkt_valid`=0, `pkt_last`=0, `pkt_data`=0, `in_ack`=0, `busy`=0.
  - Internal state: `seq`=0, `sum`=0, `cnt`=0, state IDLE.
  - A packet in flight is abandoned with no trailer.

## Timing
- **Header latency.** `in_valid` rises before edge k with `slot_free` → the header is valid after edge k. The first payload word can be acked in cycle k+1.
- **Throughput.** One word per cycle when `pkt_ready`=1 and `in_valid`=1. A packet occupies `PKT_WORDS`+2 cycles minimum. The next header can load in the cycle after the trailer loads.
- **Payload latency.** A word accepted at edge j appears on `pkt_data` after edge j, i.e. 1 cycle.
- **Backpressure.**
  - `pkt_ready`=0 with `pkt_valid`=1 → `pkt_data`, `pkt_valid` and `pkt_last` are held stable.
  - Under the same condition `in_ack`=0 in the same cycle (combinational path `pkt_ready` → `in_ack`).
- **Same-edge events.** Downstream drain and upstream accept on the same edge are legal and lose no data.
- **PKT_WORDS=1.** Header, one payload word and trailer; the trailer equals that word.

## Test plan
1. **Basic packet.** Reset, `PKT_WORDS`=4, `pkt_ready`=1, FIFO supplies 1,2,3,4 → `pkt_data` sequence A5000004, 1, 2, 3, 4, 0000000A. `pkt_last`=1 only on 0000000A. Total 6 consecutive valid cycles.
2. **Backpressure.** Same stimulus with `pkt_ready` toggling 1,0,0,1,… → every word is held while `pkt_ready`=0, `in_ack`=0 in those cycles, and the output sequence is identical to scenario 1 with no duplicates.
3. **Upstream starvation.** `in_valid` low for 5 cycles after word 2 → `pkt_valid` low during the gap, no early trailer, state stays PAYLOAD, and the trailer after words 3 and 4 is still 0000000A.
4. **Checksum wrap.** Payload FFFFFFFF, FFFFFFFF, 00000002, 00000000 → trailer 00000000.
5. **Sequence wrap.** 257 back-to-back packets → header of packet 256 is A5FF0004 and header of packet 257 is A5000004.
6. **Reset mid-packet.** Assert `rst` asynchronously (between edges) after payload word 2 → `pkt_valid`, `pkt_last` and `in_ack` go low immediately without a clock edge, and `pkt_data`=0. After release, the next packet header is A5000004 and its trailer covers only new words.
